// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} rx_state_t;

  localparam logic [1:0] DS_5 = 2'b00;
  localparam logic [1:0] DS_6 = 2'b01;
  localparam logic [1:0] DS_7 = 2'b10;
  localparam logic [1:0] DS_8 = 2'b11;

  typedef struct packed {
    logic [1:0] data_size;
    logic       parity_en;
    logic       parity_odd;
    logic       stop_two;
  } rx_cfg_t;

  // Keeps only the data bits that belong to the configured character width.
  function automatic logic [7:0] data_mask(input logic [1:0] ds);
    case (ds)
      DS_5:    data_mask = 8'h1f;
      DS_6:    data_mask = 8'h3f;
      DS_7:    data_mask = 8'h7f;
      default: data_mask = 8'hff;
    endcase
  endfunction

endpackage

// File: rtl/uart_parity_checker.sv
// Even parity over the active data bits of a received character.
module uart_parity_checker
  import uart_pkg::*;
(
  input  logic [1:0] data_size,
  input  logic [7:0] data,
  output logic       even_parity
);

  assign even_parity = ^(data & data_mask(data_size));

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame sequencer: 16x oversampled start/data/parity/stop
// sequencing with a one-entry valid/ready holding register.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic       baud_tick,
  input  logic       rx,
  input  logic [1:0] data_size,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       stop_two,
  output logic [7:0] rx_data,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  // Reset to idle-high so releasing reset never looks like a start edge.
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_s;

  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) rx_sync <= '1;
    else        rx_sync <= {rx_sync[SYNC_STAGES-2:0], rx};

  assign rx_s = rx_sync[SYNC_STAGES-1];

  rx_state_t     state, state_nxt;
  logic [TW-1:0] tick_cnt, tick_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          perr, perr_nxt;
  logic          ferr, ferr_nxt;
  rx_cfg_t       cfg, cfg_nxt;
  logic          publish;
  logic          even_parity;
  logic [2:0]    last_bit;

  assign last_bit = 3'd4 + {1'b0, cfg.data_size};

  uart_parity_checker u_par (
    .data_size  (cfg.data_size),
    .data       (shift),
    .even_parity(even_parity)
  );

  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      cfg      <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      perr     <= perr_nxt;
      ferr     <= ferr_nxt;
      cfg      <= cfg_nxt;
    end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    perr_nxt  = perr;
    ferr_nxt  = ferr;
    cfg_nxt   = cfg;
    publish   = 1'b0;
    if (baud_tick) begin
      case (state)
        IDLE: if (!rx_s) begin
          state_nxt = START;
          tick_nxt  = '0;
          bit_nxt   = '0;
          shift_nxt = '0;
          perr_nxt  = 1'b0;
          ferr_nxt  = 1'b0;
          cfg_nxt   = rx_cfg_t'{data_size, parity_en, parity_odd, stop_two};
        end
        // Half a bit in: a high line here means the start was only a glitch.
        START: if (tick_cnt == TICK_HALF) begin
          tick_nxt  = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end else tick_nxt = tick_cnt + 1'b1;
        DATA: if (tick_cnt == TICK_LAST) begin
          tick_nxt           = '0;
          shift_nxt[bit_cnt] = rx_s;
          if (bit_cnt == last_bit) state_nxt = cfg.parity_en ? PARITY : STOP1;
          else                     bit_nxt   = bit_cnt + 1'b1;
        end else tick_nxt = tick_cnt + 1'b1;
        PARITY: if (tick_cnt == TICK_LAST) begin
          tick_nxt  = '0;
          perr_nxt  = rx_s != (even_parity ^ cfg.parity_odd);
          state_nxt = STOP1;
        end else tick_nxt = tick_cnt + 1'b1;
        STOP1: if (tick_cnt == TICK_LAST) begin
          tick_nxt = '0;
          ferr_nxt = ferr | ~rx_s;
          if (cfg.stop_two) state_nxt = STOP2;
          else begin
            publish   = 1'b1;
            state_nxt = IDLE;
          end
        end else tick_nxt = tick_cnt + 1'b1;
        STOP2: if (tick_cnt == TICK_LAST) begin
          tick_nxt  = '0;
          ferr_nxt  = ferr | ~rx_s;
          publish   = 1'b1;
          state_nxt = IDLE;
        end else tick_nxt = tick_cnt + 1'b1;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A publish into a full register that is not being drained loses the new frame.
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_valid      <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (publish) begin
        if (!rx_valid || rx_ready) begin
          rx_data       <= shift;
          rx_parity_err <= perr;
          rx_frame_err  <= ferr_nxt;
          rx_valid      <= 1'b1;
        end else overrun <= 1'b1;
      end else if (rx_valid && rx_ready) rx_valid <= 1'b0;
    end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl at 16x oversampling, tick every cycle.
module tb_uart_rx_frame_ctrl;

  localparam int OVS = 16;

  logic       clk_i = 1'b0;
  logic       arst_i = 1'b1;
  logic       baud_tick = 1'b1;
  logic       rx = 1'b1;
  logic [1:0] data_size = 2'b11;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       stop_two = 1'b0;
  logic [7:0] rx_data;
  logic       rx_parity_err, rx_frame_err, rx_valid, overrun, busy;
  logic       rx_ready = 1'b1;

  uart_rx_frame_ctrl #(.OVERSAMPLE(OVS), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .baud_tick(baud_tick), .rx(rx),
    .data_size(data_size), .parity_en(parity_en), .parity_odd(parity_odd),
    .stop_two(stop_two), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [7:0] data; logic perr; logic ferr; } exp_t;
  exp_t sb[$];

  int n_vec = 0, n_err = 0, n_rcv = 0, n_ovr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (!arst_i && rx_valid && rx_ready) begin
      n_rcv++;
      if (sb.size() == 0) chk("unexpected_frame", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rx_data", rx_data, e.data);
        chk("rx_parity_err", rx_parity_err, e.perr);
        chk("rx_frame_err", rx_frame_err, e.ferr);
      end
    end
    if (!arst_i && overrun) n_ovr++;
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (OVS) @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input logic pen,
                            input logic pbit, input logic two, input logic s2);
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(1'b1);
    if (two) drive_bit(s2);
  endtask

  task automatic set_cfg(input logic [1:0] ds, input logic pen, input logic podd, input logic two);
    data_size = ds; parity_en = pen; parity_odd = podd; stop_two = two;
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe;
    sb.push_back(e);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, rx_valid, 1'b0);
    chk({tag, "_data"}, rx_data, 8'h00);
    chk({tag, "_perr"}, rx_parity_err, 1'b0);
    chk({tag, "_ferr"}, rx_frame_err, 1'b0);
    chk({tag, "_overrun"}, overrun, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0, r0;
    logic found;
    repeat (3) @(posedge clk_i);
    #1;
    check_quiet("reset");
    arst_i = 1'b0;
    idle(20);

    // 8N1 0xA5
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    push(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(32);
    chk("8n1_busy", busy, 1'b0);

    // 7E1 0x53: four ones, good then bad parity bit
    set_cfg(2'b10, 1'b1, 1'b0, 1'b0);
    push(8'h53, 1'b0, 1'b0);
    send_frame(8'h53, 7, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(32);
    push(8'h53, 1'b1, 1'b0);
    send_frame(8'h53, 7, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(32);

    // 5O2 0x1F: parity bit 0 is correct for odd, second stop low
    set_cfg(2'b00, 1'b1, 1'b1, 1'b1);
    push(8'h1F, 1'b0, 1'b1);
    send_frame(8'h1F, 5, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(48);
    chk("5o2_busy", busy, 1'b0);

    // start glitch
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    r0 = n_rcv;
    rx = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    idle(40);
    chk("glitch_busy", busy, 1'b0);
    chk("glitch_no_valid", rx_valid, 1'b0);
    chk("glitch_no_frame", n_rcv - r0, 0);

    // back-to-back with consumer stalled: second frame overruns
    rx_ready = 1'b0;
    n0 = n_ovr;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(32);
    chk("ovr_data_held", rx_data, 8'h11);
    chk("ovr_valid", rx_valid, 1'b1);
    chk("ovr_pulses", n_ovr - n0, 1);
    push(8'h11, 1'b0, 1'b0);
    rx_ready = 1'b1;
    @(posedge clk_i);
    #1;
    rx_ready = 1'b0;
    chk("ovr_drained", rx_valid, 1'b0);

    // back-to-back with ready raised exactly on the second publish cycle
    n0 = n_ovr;
    push(8'h11, 1'b0, 1'b0);
    found = 1'b0;
    fork
      begin
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      begin
        for (int i = 0; i < 400; i++) begin
          @(posedge clk_i);
          #1;
          if (rx_valid) begin
            found = 1'b1;
            break;
          end
        end
        if (found) begin
          repeat (10 * OVS - 1) @(posedge clk_i);
          #1;
          rx_ready = 1'b1;
          @(posedge clk_i);
          #1;
          rx_ready = 1'b0;
        end
      end
    join
    chk("b2b_first_valid_seen", found, 1'b1);
    idle(32);
    chk("b2b_data", rx_data, 8'h22);
    chk("b2b_valid", rx_valid, 1'b1);
    chk("b2b_no_overrun", n_ovr - n0, 0);
    push(8'h22, 1'b0, 1'b0);
    rx_ready = 1'b1;
    @(posedge clk_i);
    #1;

    // reset in the middle of data bit 3 of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    repeat (OVS / 2) @(posedge clk_i);
    #1;
    chk("mid_frame_busy", busy, 1'b1);
    arst_i = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_quiet("in_reset");
    arst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_quiet("post_reset");
    idle(32);
    push(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(32);

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Receive-side frame sequencer for the UART. It oversamples the serial line at 16x, sequences start, data, parity and stop bits, and assembles 5–8 data bits. It computes parity with a uart_parity_checker instance and presents each frame on a one-entry valid/ready holding register, with parity, framing and overrun status. It sits between the baud generator (tick source) and the RX FIFO.

Parameters:
OVERSAMPLE, 16, baud_tick pulses per bit period; power of two ≥ 4
SYNC_STAGES, 2, rx synchroniser flops; ≥ 2

Ports:
clk_i  input  1  system clock
arst_i  input  1  asynchronous active-high reset
baud_tick  input  1  one-cycle pulse, OVERSAMPLE per bit
rx  input  1  asynchronous serial line, idle high
data_size  input  2  00=5, 01=6, 10=7, 11=8 data bits
parity_en  input  1  parity bit present
parity_odd  input  1  0 = even parity, 1 = odd parity
stop_two  input  1  two stop bits
rx_data  output  8  received data, LSB first, upper bits zero when data_size < 11
rx_parity_err  output  1  parity mismatch for the held frame
rx_frame_err  output  1  stop bit sampled low for the held frame
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts when rx_valid && rx_ready
overrun  output  1  one-cycle pulse: completed frame dropped
busy  output  1  state != IDLE

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE, counters=0, all outputs 0, synchroniser flops=1 (no false start on release).
- Counters and FSM advance only on cycles with baud_tick=1. All other cycles hold state, except the consumer handshake.
- Config (data_size, parity_en, parity_odd, stop_two) is latched on the IDLE→START transition. Changes mid-frame are ignored.
- FSM:
  - IDLE: on tick with rx_s=0 → START, tick_cnt=0.
  - START: at tick_cnt=OVERSAMPLE/2-1, sample rx_s. If 1, the start was false → IDLE. If 0, → DATA, tick_cnt=0, bit_cnt=0.
  - DATA: sample at tick_cnt=OVERSAMPLE-1 (mid-bit) into shift register bit[bit_cnt]. After bit index 4+data_size, go to PARITY if parity_en, else STOP1.
  - PARITY: sample at mid-bit. Expected bit = even_parity ^ parity_odd, where even_parity is XOR of the masked data from the checker. parity_err = sample != expected.
  - STOP1: sample at mid-bit; frame_err |= ~sample. Then → STOP2 if stop_two, else publish and → IDLE.
  - STOP2: sample at mid-bit; frame_err |= ~sample. Publish and → IDLE.
  - The FSM returns to IDLE at the stop-bit midpoint, so back-to-back frames resync on the next start edge.
- Publish (registered; rx_valid rises 1 cycle after the final stop sample tick):
  - If the holding register is empty, or rx_valid && rx_ready in the same cycle: load data and error flags, rx_valid=1.
  - Otherwise: keep the old frame, pulse overrun for 1 cycle, discard the new frame.
- Handshake: rx_valid && rx_ready with no simultaneous publish → rx_valid=0 next cycle. rx_data and error flags are held until consumed.
- frame_err with rx low for the entire frame (break) is reported only as a frame error. No separate break indication.
- Parity bits are unused when parity_en=0; rx_parity_err=0.

Decomposition:
- uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP1, STOP2)
  - data_size encoding constants (DS_5..DS_8)
  - rx_cfg_t struct {data_size, parity_en, parity_odd, stop_two}
- Sub-module: one uart_parity_checker instance fed by the latched data_size and the shift register.
- The synchroniser is inline flops. No other sub-modules.

Test Plan:
- 8N1, 0xA5, baud_tick every cycle, rx_ready=1 → rx_valid pulses with rx_data=0xA5, both error flags 0, busy low after the stop midpoint.
- 7E1, data 0x53 (four ones) with parity bit 0 → rx_data=0x53, parity_err=0. Same frame with parity bit 1 → parity_err=1.
- 5O2, data 0x1F (five ones) with parity 0 and the second stop bit driven low → rx_data=0x1F, parity_err=0, frame_err=1.
- rx low for 4 ticks, then high (glitch) → FSM returns to IDLE, no rx_valid, busy deasserts.
- Two back-to-back 8N1 frames 0x11, 0x22 with rx_ready=0 → rx_data stays 0x11, overrun pulses once. Repeat with rx_ready=1 on the second publish cycle → 0x22 loaded, no overrun.
- Assert arst_i during DATA bit 3 of 0xFF, release with rx high → all outputs 0, IDLE, next frame 0x3C received correctly.
